// File: rtl/mem_pkg.sv
// Shared types and constants for the s4 memory-access stage.
// Op encodings, access sizes and the stage FSM states.
package mem_pkg;

    localparam logic [3:0] OP_MATH = 4'd0;
    localparam logic [3:0] OP_LDST = 4'd1;
    localparam logic [3:0] OP_BR   = 4'd2;
    localparam logic [3:0] OP_JMP  = 4'd3;
    localparam logic [3:0] OP_UPI  = 4'd4;

    localparam logic [4:0] LB  = 5'd0;
    localparam logic [4:0] LH  = 5'd1;
    localparam logic [4:0] LW  = 5'd2;
    localparam logic [4:0] LBU = 5'd3;
    localparam logic [4:0] LHU = 5'd4;
    localparam logic [4:0] SB  = 5'd5;
    localparam logic [4:0] SH  = 5'd6;
    localparam logic [4:0] SW  = 5'd7;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  spec;
        logic        we;
        logic [4:0]  rd_ind;
    } req_t;

    function automatic size_t size_of(input logic [4:0] spec);
        case (spec)
            LB, LBU, SB: size_of = SZ_B;
            LH, LHU, SH: size_of = SZ_H;
            default:     size_of = SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory req/ack port between the s4 stage and dmem.
// master = stage side, slave = memory side.
interface mem_access_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering for loads/stores and alignment check.
// Purely combinational.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [4:0]  spec,
    input  logic        we,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        aligned,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_ext
);
    logic [7:0]  b;
    logic [15:0] h;
    logic        uns;

    // lane select, replication and extension by access size
    always_comb begin
        b          = rdata[{addr_lo, 3'b000} +: 8];
        h          = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        uns        = (spec == LBU) || (spec == LHU);
        aligned    = 1'b1;
        be         = 4'hf;
        wdata_lane = wdata;
        load_ext   = rdata;
        case (size_of(spec))
            SZ_B: begin
                if (we) be = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                load_ext   = uns ? {24'h0, b} : {{24{b[7]}}, b};
            end
            SZ_H: begin
                aligned = !addr_lo[0];
                if (we) be = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_lane = {2{wdata[15:0]}};
                load_ext   = uns ? {16'h0, h} : {{16{h[15]}}, h};
            end
            default: aligned = (addr_lo == 2'b00);
        endcase
    end
endmodule

// File: rtl/mem_access.sv
// s4 memory-access stage: loads/stores over req/ack dmem port.
// Stalls upstream during an access, emits registered wb bundle.
module mem_access
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int CW          = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_in,
    input  logic [3:0]    op_type,
    input  logic [4:0]    op_spec,
    input  logic [4:0]    rd_ind,
    input  logic [31:0]   rd_dat,
    input  logic [31:0]   mem_addr,
    input  logic [31:0]   mem_dat,
    input  logic          mem_read_en,
    input  logic          mem_write_en,
    output logic          stall_out,
    mem_access_if.master  dmem,
    output logic          wb_valid,
    output logic          wb_en,
    output logic [4:0]    wb_rd_ind,
    output logic [31:0]   wb_rd_dat,
    output logic          exc_misalign,
    output logic          exc_bus
);
    state_t        state, state_nx;
    req_t          cap;
    logic [CW-1:0] cnt;

    logic          idle, take, is_mem, accept, misal, pass;
    logic          req, done_now, timeout;
    logic [31:0]   a_addr, a_wdata, wlane, ld;
    logic [4:0]    a_spec, a_rd;
    logic          a_we, aligned;
    logic [3:0]    be;

    assign idle   = (state == IDLE);
    assign a_addr  = idle ? mem_addr     : cap.addr;
    assign a_wdata = idle ? mem_dat      : cap.wdata;
    assign a_spec  = idle ? op_spec      : cap.spec;
    assign a_we    = idle ? mem_write_en : cap.we;
    assign a_rd    = idle ? rd_ind       : cap.rd_ind;

    mem_lane_align u_align (
        .addr_lo    (a_addr[1:0]),
        .spec       (a_spec),
        .we         (a_we),
        .wdata      (a_wdata),
        .rdata      (dmem.dmem_rdata),
        .aligned    (aligned),
        .be         (be),
        .wdata_lane (wlane),
        .load_ext   (ld)
    );

    assign is_mem   = (op_type == OP_LDST) && (mem_read_en || mem_write_en);
    assign take     = !rst && idle && valid_in;
    assign accept   = take && is_mem && aligned;
    assign misal    = take && is_mem && !aligned;
    assign pass     = take && !is_mem;
    assign req      = !rst && (accept || state == ACCESS);
    assign done_now = req && dmem.dmem_ack;
    assign timeout  = (state == ACCESS) && !dmem.dmem_ack
                      && (cnt == CW'(TIMEOUT_CYC - 1));

    assign stall_out       = req;
    assign dmem.dmem_req   = req;
    assign dmem.dmem_we    = req && a_we;
    assign dmem.dmem_addr  = req ? {a_addr[31:2], 2'b00} : 32'h0;
    assign dmem.dmem_be    = req ? be : 4'h0;
    assign dmem.dmem_wdata = req ? wlane : 32'h0;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next-state: same-cycle ack from IDLE goes straight to DONE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = dmem.dmem_ack ? DONE : ACCESS;
            ACCESS:  if (dmem.dmem_ack) state_nx = DONE;
                     else if (timeout) state_nx = IDLE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // request capture, wait counter and writeback bundle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap          <= '0;
            cnt          <= '0;
            wb_valid     <= 1'b0;
            wb_en        <= 1'b0;
            wb_rd_ind    <= 5'd0;
            wb_rd_dat    <= 32'h0;
            exc_misalign <= 1'b0;
            exc_bus      <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            exc_misalign <= 1'b0;
            exc_bus      <= 1'b0;
            if (accept) begin
                cap <= '{addr: mem_addr, wdata: mem_dat, spec: op_spec,
                         we: mem_write_en, rd_ind: rd_ind};
                cnt <= '0;
            end else if (state == ACCESS) begin
                cnt <= cnt + 1'b1;
            end
            if (pass) begin
                wb_valid  <= 1'b1;
                wb_en     <= (op_type == OP_MATH || op_type == OP_JMP
                              || op_type == OP_UPI) && (rd_ind != 5'd0);
                wb_rd_ind <= rd_ind;
                wb_rd_dat <= rd_dat;
            end
            if (misal) begin
                wb_valid     <= 1'b1;
                wb_en        <= 1'b0;
                wb_rd_ind    <= rd_ind;
                exc_misalign <= 1'b1;
            end
            if (done_now) begin
                wb_valid  <= 1'b1;
                wb_en     <= !a_we && (a_rd != 5'd0);
                wb_rd_ind <= a_rd;
                if (!a_we) wb_rd_dat <= ld;
            end
            if (timeout) begin
                wb_valid  <= 1'b1;
                wb_en     <= 1'b0;
                wb_rd_ind <= cap.rd_ind;
                exc_bus   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for the s4 memory-access stage.
// Expected wb bundles are queued at issue and popped on wb_valid.
module tb_mem_access;
    import mem_pkg::*;

    typedef struct {
        logic        en;
        logic [4:0]  rd;
        logic [31:0] dat;
        logic        cd;
        logic        mis;
        logic        bus;
    } exp_t;

    logic        clk = 0;
    logic        rst;
    logic        valid_in;
    logic [3:0]  op_type;
    logic [4:0]  op_spec, rd_ind;
    logic [31:0] rd_dat, mem_addr, mem_dat;
    logic        mem_read_en, mem_write_en;
    logic        stall_out, wb_valid, wb_en, exc_misalign, exc_bus;
    logic [4:0]  wb_rd_ind;
    logic [31:0] wb_rd_dat;

    int   n_chk = 0;
    int   n_err = 0;
    exp_t q[$];

    mem_access_if bus ();

    mem_access #(.TIMEOUT_CYC(4), .CW(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .op_type      (op_type),
        .op_spec      (op_spec),
        .rd_ind       (rd_ind),
        .rd_dat       (rd_dat),
        .mem_addr     (mem_addr),
        .mem_dat      (mem_dat),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .stall_out    (stall_out),
        .dmem         (bus.master),
        .wb_valid     (wb_valid),
        .wb_en        (wb_en),
        .wb_rd_ind    (wb_rd_ind),
        .wb_rd_dat    (wb_rd_dat),
        .exc_misalign (exc_misalign),
        .exc_bus      (exc_bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // scoreboard: every wb_valid cycle must match the next queued entry
    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            if (q.size() == 0) begin
                check("wb_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("wb_en", wb_en, e.en);
                check("wb_rd_ind", wb_rd_ind, e.rd);
                if (e.cd) check("wb_rd_dat", wb_rd_dat, e.dat);
                check("exc_misalign", exc_misalign, e.mis);
                check("exc_bus", exc_bus, e.bus);
            end
        end else if (!rst && (exc_misalign || exc_bus)) begin
            check("exc_stray", 32'd1, 32'd0);
        end
    end

    task automatic idle_in();
        valid_in = 0; op_type = 0; op_spec = 0; rd_ind = 0; rd_dat = 0;
        mem_addr = 0; mem_dat = 0; mem_read_en = 0; mem_write_en = 0;
    endtask

    task automatic non_mem(input logic [3:0] t, input logic [4:0] rd,
                           input logic [31:0] d, input logic en_set,
                           input logic exp_en);
        @(negedge clk);
        valid_in = 1; op_type = t; rd_ind = rd; rd_dat = d;
        mem_read_en = en_set; mem_addr = 32'h10;
        q.push_back('{en: exp_en, rd: rd, dat: d, cd: 1, mis: 0, bus: 0});
        #1;
        check("nm_stall", stall_out, 0);
        check("nm_req", bus.dmem_req, 0);
        @(negedge clk);
        idle_in();
    endtask

    task automatic mem_op(input logic [4:0] spec, input logic wr,
                          input logic [31:0] addr, wd, rdat,
                          input int dly, input logic [3:0] ebe,
                          input logic [31:0] ewd, eld,
                          input logic [4:0] rd);
        @(negedge clk);
        valid_in = 1; op_type = OP_LDST; op_spec = spec; rd_ind = rd;
        mem_addr = addr; mem_dat = wd; mem_read_en = !wr;
        mem_write_en = wr;
        q.push_back('{en: !wr && rd != 0, rd: rd, dat: eld, cd: !wr,
                      mis: 0, bus: 0});
        for (int i = 0; i <= dly; i++) begin
            #1;
            check("req", bus.dmem_req, 1);
            check("stall", stall_out, 1);
            check("we", bus.dmem_we, wr);
            check("addr", bus.dmem_addr, {addr[31:2], 2'b00});
            check("be", bus.dmem_be, ebe);
            if (wr) check("wdata", bus.dmem_wdata, ewd);
            if (i == dly) begin
                bus.dmem_ack = 1; bus.dmem_rdata = rdat;
            end
            @(negedge clk);
            bus.dmem_ack = 0;
        end
        #1;
        check("done_stall", stall_out, 0);
        check("done_req", bus.dmem_req, 0);
        @(negedge clk);
        idle_in();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1;
        idle_in();
        bus.dmem_ack = 0;
        bus.dmem_rdata = 0;
        #12;
        check("rst_req", bus.dmem_req, 0);
        check("rst_stall", stall_out, 0);
        check("rst_wbv", wb_valid, 0);
        check("rst_exc", {exc_misalign, exc_bus}, 0);
        @(negedge clk);
        rst = 0;

        non_mem(OP_MATH, 5'd5, 32'h2A, 0, 1);
        non_mem(OP_BR, 5'd7, 32'h11, 0, 0);
        non_mem(OP_MATH, 5'd0, 32'h33, 0, 0);
        non_mem(OP_JMP, 5'd9, 32'h44, 1, 1);
        non_mem(OP_UPI, 5'd3, 32'hABCD_0000, 0, 1);

        mem_op(LB, 0, 32'h1003, 0, 32'h80FF_1234, 3, 4'hf, 0,
               32'hFFFF_FF80, 5'd6);
        mem_op(LBU, 0, 32'h1003, 0, 32'h80FF_1234, 3, 4'hf, 0,
               32'h0000_0080, 5'd6);
        mem_op(SH, 1, 32'h2002, 32'hDEAD_BEEF, 0, 1, 4'b1100,
               32'hBEEF_BEEF, 0, 5'd8);
        mem_op(SB, 1, 32'h0011, 32'h0000_00A5, 0, 2, 4'b0010,
               32'hA5A5_A5A5, 0, 5'd1);
        mem_op(SW, 1, 32'h0020, 32'h1234_5678, 0, 0, 4'hf,
               32'h1234_5678, 0, 5'd1);
        mem_op(LW, 0, 32'h0040, 0, 32'h1234_5678, 0, 4'hf, 0,
               32'h1234_5678, 5'd10);
        mem_op(LH, 0, 32'h1002, 0, 32'h80FF_1234, 1, 4'hf, 0,
               32'hFFFF_80FF, 5'd11);
        mem_op(LHU, 0, 32'h1002, 0, 32'h80FF_1234, 1, 4'hf, 0,
               32'h0000_80FF, 5'd12);

        // misaligned word load
        @(negedge clk);
        valid_in = 1; op_type = OP_LDST; op_spec = LW; rd_ind = 5'd4;
        mem_addr = 32'h6; mem_read_en = 1;
        q.push_back('{en: 0, rd: 5'd4, dat: 0, cd: 0, mis: 1, bus: 0});
        #1;
        check("mis_req", bus.dmem_req, 0);
        check("mis_stall", stall_out, 0);
        @(negedge clk);
        idle_in();

        // ack timeout after 4 ACCESS cycles
        @(negedge clk);
        valid_in = 1; op_type = OP_LDST; op_spec = LW; rd_ind = 5'd2;
        mem_addr = 32'h100; mem_read_en = 1;
        q.push_back('{en: 0, rd: 5'd2, dat: 0, cd: 0, mis: 0, bus: 1});
        for (int i = 0; i < 5; i++) begin
            #1;
            check("to_req", bus.dmem_req, 1);
            @(negedge clk);
        end
        idle_in();
        #1;
        check("to_req_drop", bus.dmem_req, 0);
        check("to_stall", stall_out, 0);
        @(negedge clk);
        bus.dmem_ack = 1;
        #1;
        check("late_req", bus.dmem_req, 0);
        @(negedge clk);
        bus.dmem_ack = 0;
        check("late_wbv", wb_valid, 0);
        @(negedge clk);
        check("late_wbv2", wb_valid, 0);

        // reset in the middle of an access
        @(negedge clk);
        valid_in = 1; op_type = OP_LDST; op_spec = LW; rd_ind = 5'd3;
        mem_addr = 32'h80; mem_read_en = 1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("pre_rst_req", bus.dmem_req, 1);
        #2;
        rst = 1;
        idle_in();
        #1;
        check("mid_rst_req", bus.dmem_req, 0);
        check("mid_rst_stall", stall_out, 0);
        check("mid_rst_wbv", wb_valid, 0);
        @(negedge clk);
        rst = 0;
        mem_op(LW, 0, 32'h0084, 0, 32'hCAFE_F00D, 2, 4'hf, 0,
               32'hCAFE_F00D, 5'd13);

        @(negedge clk);
        @(negedge clk);
        check("sb_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end
endmodule
